// File: rtl/bus_demux.sv
// bus_demux: steers one LSU request to data RAM (t0) or MMIO (t1); one transaction in flight.
// Optional WAIT watchdog with DEAD_BEEF error response: define BUS_DEMUX_TIMEOUT_EN.
//   state | meaning
//   IDLE  | req_ready high, latch request on req_valid
//   ISSUE | t[sel]_valid high until t[sel]_ready
//   WAIT  | await t[sel]_rvalid (or watchdog expiry)
//   RESP  | one-cycle resp_valid pulse
module bus_demux #(
  parameter logic [31:0] T1_BASE        = 32'h1000_0000,
  parameter logic [31:0] T1_MASK        = 32'hF000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        t0_valid,
  input  logic        t0_ready,
  output logic [31:0] t0_addr,
  output logic        t0_we,
  output logic [31:0] t0_wdata,
  output logic [3:0]  t0_wstrb,
  input  logic        t0_rvalid,
  input  logic [31:0] t0_rdata,
  output logic        t1_valid,
  input  logic        t1_ready,
  output logic [31:0] t1_addr,
  output logic        t1_we,
  output logic [31:0] t1_wdata,
  output logic [3:0]  t1_wstrb,
  input  logic        t1_rvalid,
  input  logic [31:0] t1_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // The watchdog counter is 8 bits wide, so the last count must fit.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
    $error("bus_demux: TIMEOUT_CYCLES must be in 1..256");
  end

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        we_q, we_d;
  logic        sel_q, sel_d;

  logic        tgt_ready;
  logic        tgt_rvalid;
  logic [31:0] tgt_rdata;

`ifdef BUS_DEMUX_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  assign tgt_ready  = sel_q ? t1_ready  : t0_ready;
  assign tgt_rvalid = sel_q ? t1_rvalid : t0_rvalid;
  assign tgt_rdata  = sel_q ? t1_rdata  : t0_rdata;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    we_d    = we_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
`ifdef BUS_DEMUX_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          we_d    = req_we;
          sel_d   = ((req_addr & T1_MASK) == T1_BASE);
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (tgt_ready) begin
          state_d = S_WAIT;
`ifdef BUS_DEMUX_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      S_WAIT: begin
        // A completion arriving on the expiry cycle still counts as a normal response.
        if (tgt_rvalid) begin
          rdata_d = tgt_rdata;
          state_d = S_RESP;
`ifdef BUS_DEMUX_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
`ifdef BUS_DEMUX_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          rdata_d = 32'hDEAD_BEEF;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      we_q    <= 1'b0;
      sel_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef BUS_DEMUX_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;

  assign t0_valid = (state_q == S_ISSUE) && !sel_q;
  assign t1_valid = (state_q == S_ISSUE) &&  sel_q;
  assign t0_addr  = addr_q;
  assign t0_we    = we_q;
  assign t0_wdata = wdata_q;
  assign t0_wstrb = wstrb_q;
  assign t1_addr  = addr_q;
  assign t1_we    = we_q;
  assign t1_wdata = wdata_q;
  assign t1_wstrb = wstrb_q;

endmodule

// File: tb/tb_bus_demux.sv
// Directed bench for bus_demux: scoreboard of expected responses popped on resp_valid.
module tb_bus_demux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        t0_valid, t0_ready, t0_we, t0_rvalid;
  logic [31:0] t0_addr, t0_wdata, t0_rdata;
  logic [3:0]  t0_wstrb;
  logic        t1_valid, t1_ready, t1_we, t1_rvalid;
  logic [31:0] t1_addr, t1_wdata, t1_rdata;
  logic [3:0]  t1_wstrb;

  bus_demux #(
    .T1_BASE(32'h1000_0000), .T1_MASK(32'hF000_0000), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .t0_valid(t0_valid), .t0_ready(t0_ready), .t0_addr(t0_addr), .t0_we(t0_we),
    .t0_wdata(t0_wdata), .t0_wstrb(t0_wstrb), .t0_rvalid(t0_rvalid), .t0_rdata(t0_rdata),
    .t1_valid(t1_valid), .t1_ready(t1_ready), .t1_addr(t1_addr), .t1_we(t1_we),
    .t1_wdata(t1_wdata), .t1_wstrb(t1_wstrb), .t1_rvalid(t1_rvalid), .t1_rdata(t1_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int resp_cnt = 0;
  int last_resp_cyc = -100;
  int t0_vcnt = 0;
  int t1_vcnt = 0;
  logic [32:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; pop and compare the scoreboard on any response pulse.
  task automatic step();
    logic [32:0] e;
    @(negedge clk);
    cyc++;
    if (t0_valid === 1'b1) t0_vcnt++;
    if (t1_valid === 1'b1) t1_vcnt++;
    if (resp_valid === 1'b1) begin
      resp_cnt++;
      last_resp_cyc = cyc;
      chk("sb_nonempty_at_resp", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("resp_rdata", resp_rdata, e[31:0]);
        chk("resp_err", 32'(resp_err), 32'(e[32]));
      end
    end
  endtask

  task automatic txn(input logic [31:0] a, input logic we, input logic [31:0] wd,
                     input logic [3:0] ws, input int rdy_dly, input int rv_dly,
                     input logic [31:0] rd, input bit stray, input bit s);
    int v0, v1, r0;
    v0 = t0_vcnt; v1 = t1_vcnt; r0 = resp_cnt;
    chk("idle_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_addr = a; req_we = we; req_wdata = wd; req_wstrb = ws;
    step();
    req_valid = 1'b0; req_addr = ~a; req_we = ~we; req_wdata = ~wd; req_wstrb = ~ws;
    for (int k = 0; k <= rdy_dly; k++) begin
      chk("issue_valid_sel", 32'(s ? t1_valid : t0_valid), 32'd1);
      chk("issue_valid_other", 32'(s ? t0_valid : t1_valid), 32'd0);
      chk("issue_req_ready", 32'(req_ready), 32'd0);
      chk("t0_addr", t0_addr, a);
      chk("t1_addr", t1_addr, a);
      chk("t_we", 32'(s ? t1_we : t0_we), 32'(we));
      chk("t_wdata", s ? t1_wdata : t0_wdata, wd);
      chk("t_wstrb", 32'(s ? t1_wstrb : t0_wstrb), 32'(ws));
      if (s) t1_ready = (k == rdy_dly); else t0_ready = (k == rdy_dly);
      if (stray) begin
        if (s) begin t1_rvalid = 1'b1; t1_rdata = 32'h1234_5678; end
        else   begin t0_rvalid = 1'b1; t0_rdata = 32'h1234_5678; end
      end
      step();
    end
    t0_ready = 1'b0; t1_ready = 1'b0; t0_rvalid = 1'b0; t1_rvalid = 1'b0;
    for (int j = 0; j < rv_dly; j++) begin
      chk("wait_valid_low", 32'(t0_valid | t1_valid), 32'd0);
      if (stray && j == 0) begin
        if (s) begin t0_rvalid = 1'b1; t0_rdata = 32'h1234_5678; end
        else   begin t1_rvalid = 1'b1; t1_rdata = 32'h1234_5678; end
      end
      step();
      t0_rvalid = 1'b0; t1_rvalid = 1'b0;
    end
    chk("wait_valid_low", 32'(t0_valid | t1_valid), 32'd0);
    if (s) begin t1_rvalid = 1'b1; t1_rdata = rd; end
    else   begin t0_rvalid = 1'b1; t0_rdata = rd; end
    if (stray) begin
      if (s) begin t0_rvalid = 1'b1; t0_rdata = 32'h1234_5678; end
      else   begin t1_rvalid = 1'b1; t1_rdata = 32'h1234_5678; end
    end
    sb_q.push_back({1'b0, rd});
    step();
    t0_rvalid = 1'b0; t1_rvalid = 1'b0; t0_rdata = 32'hFFFF_FFFF; t1_rdata = 32'hFFFF_FFFF;
    chk("resp_valid_pulse", 32'(resp_valid), 32'd1);
    step();
    chk("resp_valid_one_cycle", 32'(resp_valid), 32'd0);
    chk("back_to_idle", 32'(req_ready), 32'd1);
    chk("rdata_hold", resp_rdata, rd);
    chk("resp_count", 32'(resp_cnt - r0), 32'd1);
    chk("sel_valid_cycles", 32'(s ? t1_vcnt - v1 : t0_vcnt - v0), 32'(rdy_dly + 1));
    chk("other_valid_cycles", 32'(s ? t0_vcnt - v0 : t1_vcnt - v1), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, first;
    req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_wdata = '0; req_wstrb = '0;
    t0_ready = 1'b0; t0_rvalid = 1'b0; t0_rdata = '0;
    t1_ready = 1'b0; t1_rvalid = 1'b0; t1_rdata = '0;
    step(); step();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_t0_valid", 32'(t0_valid), 32'd0);
    chk("rst_t1_valid", 32'(t1_valid), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_t0_addr", t0_addr, 32'd0);
    chk("rst_t1_we", 32'(t1_we), 32'd0);
    chk("rst_t0_wdata", t0_wdata, 32'd0);
    chk("rst_t1_wstrb", 32'(t1_wstrb), 32'd0);
    rst_n = 1'b1;
    step();

    // T1 RAM load, T2 MMIO store with delayed ready, T3 stray responses
    txn(32'h0000_0040, 1'b0, 32'h0, 4'h0, 0, 0, 32'hAAAA_AAAA, 1'b0, 1'b0);
    txn(32'h1000_0004, 1'b1, 32'h5555_5555, 4'hF, 3, 0, 32'h0000_00A5, 1'b0, 1'b1);
    txn(32'h0000_0100, 1'b0, 32'h0, 4'h0, 0, 2, 32'h0BAD_F00D, 1'b1, 1'b0);
    txn(32'h1000_0010, 1'b0, 32'h0, 4'h0, 1, 1, 32'h600D_CAFE, 1'b1, 1'b1);

    // Decode window edges
    txn(32'h1FFF_FFFC, 1'b0, 32'h0, 4'h0, 1, 0, 32'h0000_0001, 1'b0, 1'b1);
    txn(32'h2000_0000, 1'b1, 32'hC0DE_0002, 4'h5, 1, 0, 32'h0000_0002, 1'b0, 1'b0);
    txn(32'hF000_0000, 1'b0, 32'h0, 4'h0, 0, 1, 32'h0000_0003, 1'b0, 1'b0);
    txn(32'h0FFF_FFFC, 1'b0, 32'h0, 4'h0, 0, 0, 32'h0000_0004, 1'b0, 1'b0);

    // T4 reset in ISSUE drops valid at once, then reset mid-WAIT with a late rvalid
    r0 = resp_cnt;
    req_valid = 1'b1; req_addr = 32'h1000_0080; req_we = 1'b0;
    step();
    req_valid = 1'b0;
    chk("t4_issue_t1_valid", 32'(t1_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t4_async_t1_valid", 32'(t1_valid), 32'd0);
    chk("t4_async_ready_issue", 32'(req_ready), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    req_valid = 1'b1; req_addr = 32'h0000_0080;
    step();
    req_valid = 1'b0; t0_ready = 1'b1;
    step();
    t0_ready = 1'b0;
    chk("t4_wait_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("t4_async_req_ready", 32'(req_ready), 32'd1);
    chk("t4_async_t0_valid", 32'(t0_valid), 32'd0);
    chk("t4_async_resp_valid", 32'(resp_valid), 32'd0);
    chk("t4_async_rdata", resp_rdata, 32'd0);
    chk("t4_async_t0_addr", t0_addr, 32'd0);
    step();
    rst_n = 1'b1; t0_rvalid = 1'b1; t0_rdata = 32'hFFFF_0000;
    step();
    t0_rvalid = 1'b0;
    chk("t4_late_rvalid_resp", 32'(resp_valid), 32'd0);
    chk("t4_late_rvalid_ready", 32'(req_ready), 32'd1);
    step();
    chk("t4_no_resp", 32'(resp_valid), 32'd0);
    chk("t4_rdata_still_reset", resp_rdata, 32'd0);
    chk("t4_resp_count", 32'(resp_cnt - r0), 32'd0);

    // T5 back-to-back with req_valid held high: RAM then MMIO
    t0_ready = 1'b1; t1_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h0000_0200; req_we = 1'b0;
    step();
    chk("t5_a_t0_valid", 32'(t0_valid), 32'd1);
    chk("t5_a_t1_valid", 32'(t1_valid), 32'd0);
    chk("t5_a_ready_issue", 32'(req_ready), 32'd0);
    step();
    chk("t5_a_ready_wait", 32'(req_ready), 32'd0);
    t0_rvalid = 1'b1; t0_rdata = 32'h1111_2222;
    sb_q.push_back({1'b0, 32'h1111_2222});
    step();
    t0_rvalid = 1'b0;
    chk("t5_a_resp", 32'(resp_valid), 32'd1);
    chk("t5_a_ready_resp", 32'(req_ready), 32'd0);
    first = last_resp_cyc;
    req_addr = 32'h1000_0200; req_we = 1'b1; req_wdata = 32'h9999_8888; req_wstrb = 4'h3;
    step();
    chk("t5_idle_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    chk("t5_b_t1_valid", 32'(t1_valid), 32'd1);
    chk("t5_b_t0_valid", 32'(t0_valid), 32'd0);
    chk("t5_b_t1_addr", t1_addr, 32'h1000_0200);
    chk("t5_b_t1_we", 32'(t1_we), 32'd1);
    step();
    t1_rvalid = 1'b1; t1_rdata = 32'h3333_4444;
    sb_q.push_back({1'b0, 32'h3333_4444});
    step();
    t1_rvalid = 1'b0;
    chk("t5_b_resp", 32'(resp_valid), 32'd1);
    chk("t5_spacing", 32'(last_resp_cyc - first), 32'd4);
    t0_ready = 1'b0; t1_ready = 1'b0;
    step();

`ifdef BUS_DEMUX_TIMEOUT_EN
    // T6 watchdog expiry, late rvalid ignored, then rvalid on the expiry cycle wins
    r0 = resp_cnt;
    req_valid = 1'b1; req_addr = 32'h0000_0300; req_we = 1'b0;
    step();
    req_valid = 1'b0; t0_ready = 1'b1;
    step();
    t0_ready = 1'b0;
    sb_q.push_back({1'b1, 32'hDEAD_BEEF});
    for (int k = 0; k < 4; k++) begin
      chk("t6_no_early_resp", 32'(resp_valid), 32'd0);
      step();
    end
    chk("t6_timeout_resp", 32'(resp_valid), 32'd1);
    step();
    t0_rvalid = 1'b1; t0_rdata = 32'h5A5A_5A5A;
    step();
    t0_rvalid = 1'b0;
    chk("t6_late_rvalid", 32'(resp_valid), 32'd0);
    step();
    chk("t6_late_rvalid2", 32'(resp_valid), 32'd0);
    chk("t6_rdata_hold", resp_rdata, 32'hDEAD_BEEF);
    chk("t6_resp_count", 32'(resp_cnt - r0), 32'd1);
    req_valid = 1'b1; req_addr = 32'h0000_0304;
    step();
    req_valid = 1'b0; t0_ready = 1'b1;
    step();
    t0_ready = 1'b0;
    for (int k = 0; k < 3; k++) step();
    t0_rvalid = 1'b1; t0_rdata = 32'h7777_0000;
    sb_q.push_back({1'b0, 32'h7777_0000});
    step();
    t0_rvalid = 1'b0;
    chk("t6_expiry_tie_resp", 32'(resp_valid), 32'd1);
    step();
`endif

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
